// File: rtl/adder_checker.sv
// adder_checker: exhaustive response checker for the W-bit adder modul.
// Sweeps every (a, b) pair, samples the sum and records mismatches.
module adder_checker #(
    parameter int W      = 2,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W:0]     y_in,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_count,
    output logic           fail_valid,
    output logic [W-1:0]   fail_a,
    output logic [W-1:0]   fail_b,
    output logic [W:0]     fail_y
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [W-1:0] OP_MAX = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [W-1:0]   a_d;
    logic [W-1:0]   b_d;
    logic           busy_d;
    logic           done_d;
    logic           pass_d;
    logic [2*W:0]   err_d;
    logic           fv_d;
    logic [W-1:0]   fa_d;
    logic [W-1:0]   fb_d;
    logic [W:0]     fy_d;

    logic [W:0]     expect_sum;
    logic           mismatch;
    logic           last_vec;
    logic [2*W:0]   err_inc;
    logic [2*W-1:0] vec_next;

    // Compare path: expected sum, mismatch flag and the stepped operand pair.
    always_comb begin
        expect_sum = {1'b0, a_out} + {1'b0, b_out};
        mismatch   = (y_in != expect_sum);
        last_vec   = (a_out == OP_MAX) && (b_out == OP_MAX);
        err_inc    = err_count + (2*W+1)'(mismatch);
        vec_next   = {a_out, b_out} + (2*W)'(1);
    end

    // State and result registers; reset discards any partial run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_out      <= '0;
            b_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_y     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_out      <= a_d;
            b_out      <= b_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            err_count  <= err_d;
            fail_valid <= fv_d;
            fail_a     <= fa_d;
            fail_b     <= fb_d;
            fail_y     <= fy_d;
        end
    end

    // Next-state logic: sweep b inner, a outer, hold each vector SETTLE+1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_out;
        b_d     = b_out;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_count;
        fv_d    = fail_valid;
        fa_d    = fail_a;
        fb_d    = fail_b;
        fy_d    = fail_y;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    fy_d    = '0;
                end
            end

            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_SAMPLE: begin
                err_d = err_inc;
                if (mismatch && !fail_valid) begin
                    fv_d = 1'b1;
                    fa_d = a_out;
                    fb_d = b_out;
                    fy_d = y_in;
                end
                if (last_vec) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_inc == '0);
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    a_d     = vec_next[2*W-1:W];
                    b_d     = vec_next[W-1:0];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // busy and done are mutually exclusive by construction.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(busy && done));
        end
    end

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: directed runs against golden and faulty adder models,
// with a cycle-count reference model checked every cycle.
module tb_adder_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0;
    logic       start1;
    logic [2:0] y0;
    logic [2:0] y1;
    logic [1:0] a0, b0, a1, b1;
    logic       busy0, done0, pass0, fv0;
    logic       busy1, done1, pass1, fv1;
    logic [4:0] err0, err1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [2:0] fy0, fy1;

    int checks   = 0;
    int failures = 0;
    int mode0    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    adder_checker #(.W(2), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_valid(fv0),
        .fail_a(fa0), .fail_b(fb0), .fail_y(fy0)
    );

    adder_checker #(.W(2), .SETTLE(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_valid(fv1),
        .fail_a(fa1), .fail_b(fb1), .fail_y(fy1)
    );

    // Adder under test: 0 golden, 1 stuck at 0, 2 bad (3,3), 3 +1 on vectors 5 and 9.
    function automatic logic [2:0] dut_sum(int md, int a, int b);
        int n = a * 4 + b;
        case (md)
            1: return 3'd0;
            2: return (a == 3 && b == 3) ? 3'd7 : 3'(a + b);
            3: return (n == 5 || n == 9) ? 3'(a + b + 1) : 3'(a + b);
            default: return 3'(a + b);
        endcase
    endfunction

    always_comb y0 = dut_sum(mode0, int'(a0), int'(b0));
    always_comb y1 = dut_sum(0, int'(a1), int'(b1));

    typedef struct {
        int a, b, busy, done, pass, err, fv, fa, fb, fy;
    } exp_t;

    // Expected outputs j edges after the start edge, from plain arithmetic.
    function automatic exp_t model(int j, int s, int md, bit started);
        exp_t e = '{default: 0};
        int h = s + 1;
        int n, cmp;
        if (!started) return e;
        n = j / h;
        if (n > 15) n = 15;
        e.a = n / 4;
        e.b = n % 4;
        e.busy = (j < 16 * h) ? 1 : 0;
        e.done = 1 - e.busy;
        cmp = j / h;
        if (cmp > 16) cmp = 16;
        for (int v = 0; v < cmp; v++) begin
            int got = int'(dut_sum(md, v / 4, v % 4));
            if (got != v / 4 + v % 4) begin
                e.err++;
                if (e.fv == 0) begin
                    e.fv = 1;
                    e.fa = v / 4;
                    e.fb = v % 4;
                    e.fy = got;
                end
            end
        end
        e.pass = (e.done == 1 && e.err == 0) ? 1 : 0;
        return e;
    endfunction

    bit st0, st1;
    int j0, j1, md0;

    // Model timebase: edge count since the accepted start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0 <= 1'b0; j0 <= 0; md0 <= 0;
            st1 <= 1'b0; j1 <= 0;
        end else begin
            if (start0 && (!st0 || j0 >= 32)) begin
                st0 <= 1'b1; j0 <= 0; md0 <= mode0;
            end else if (st0 && j0 < 32) begin
                j0 <= j0 + 1;
            end
            if (start1 && (!st1 || j1 >= 64)) begin
                st1 <= 1'b1; j1 <= 0;
            end else if (st1 && j1 < 64) begin
                j1 <= j1 + 1;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e0, e1;
            e0 = model(j0, 1, md0, st0);
            e1 = model(j1, 3, 0, st1);
            chk("u0.a_out", 32'(a0), e0.a);
            chk("u0.b_out", 32'(b0), e0.b);
            chk("u0.busy", 32'(busy0), e0.busy);
            chk("u0.done", 32'(done0), e0.done);
            chk("u0.pass", 32'(pass0), e0.pass);
            chk("u0.err_count", 32'(err0), e0.err);
            chk("u0.fail_valid", 32'(fv0), e0.fv);
            chk("u0.fail_a", 32'(fa0), e0.fa);
            chk("u0.fail_b", 32'(fb0), e0.fb);
            chk("u0.fail_y", 32'(fy0), e0.fy);
            chk("u1.a_out", 32'(a1), e1.a);
            chk("u1.b_out", 32'(b1), e1.b);
            chk("u1.busy", 32'(busy1), e1.busy);
            chk("u1.done", 32'(done1), e1.done);
            chk("u1.pass", 32'(pass1), e1.pass);
            chk("u1.err_count", 32'(err1), e1.err);
            chk("u1.fail_valid", 32'(fv1), e1.fv);
        end
    end

    // Leaves the bench at the negedge after the start edge k.
    task automatic pulse0();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic result0(string tag, int err, int fv, int fa, int fb, int fy, int ps);
        chk({tag, ".done"}, 32'(done0), 1);
        chk({tag, ".busy"}, 32'(busy0), 0);
        chk({tag, ".pass"}, 32'(pass0), ps);
        chk({tag, ".err_count"}, 32'(err0), err);
        chk({tag, ".fail_valid"}, 32'(fv0), fv);
        chk({tag, ".fail_a"}, 32'(fa0), fa);
        chk({tag, ".fail_b"}, 32'(fb0), fb);
        chk({tag, ".fail_y"}, 32'(fy0), fy);
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy0), 0);
        chk("rst.done", 32'(done0), 0);
        chk("rst.err_count", 32'(err0), 0);
        chk("rst.a_b", 32'({a0, b0}), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Golden run: literal operand sequence, done after edge k+32.
        mode0 = 0;
        pulse0();
        for (int m = 0; m < 32; m++) begin
            chk("seq.a_out", 32'(a0), (m / 2) / 4);
            chk("seq.b_out", 32'(b0), (m / 2) % 4);
            if (m == 31) begin
                chk("seq.busy_k31", 32'(busy0), 1);
                chk("seq.done_k31", 32'(done0), 0);
            end
            @(negedge clk);
        end
        result0("golden", 0, 0, 0, 0, 0, 1);

        mode0 = 1;
        pulse0();
        repeat (32) @(negedge clk);
        result0("stuck0", 15, 1, 0, 1, 0, 0);

        mode0 = 2;
        pulse0();
        repeat (32) @(negedge clk);
        result0("bad33", 1, 1, 3, 3, 7, 0);

        mode0 = 3;
        pulse0();
        repeat (32) @(negedge clk);
        result0("two_faults", 2, 1, 1, 1, 3, 0);

        // Asynchronous reset while vector (1,3) is driven.
        mode0 = 0;
        pulse0();
        repeat (14) @(negedge clk);
        chk("pre_rst.a_out", 32'(a0), 1);
        chk("pre_rst.b_out", 32'(b0), 3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst.a_b", 32'({a0, b0}), 0);
        chk("async_rst.busy", 32'(busy0), 0);
        chk("async_rst.err_count", 32'(err0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode0 = 1;
        pulse0();
        repeat (32) @(negedge clk);
        result0("after_rst", 15, 1, 0, 1, 0, 0);

        // SETTLE=3 with ignored starts while busy, then restart from DONE.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 64; m++) begin
            if (m == 63) begin
                chk("s3.busy_k63", 32'(busy1), 1);
                chk("s3.done_k63", 32'(done1), 0);
            end
            start1 = (m == 5 || m == 20 || m == 40);
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("s3.done_k64", 32'(done1), 1);
        chk("s3.busy_k64", 32'(busy1), 0);
        chk("s3.pass", 32'(pass1), 1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("s3.restart_done", 32'(done1), 0);
        chk("s3.restart_pass", 32'(pass1), 0);
        chk("s3.restart_busy", 32'(busy1), 1);
        chk("s3.restart_err", 32'(err1), 0);
        repeat (64) @(negedge clk);
        chk("s3.rerun_done", 32'(done1), 1);
        chk("s3.rerun_pass", 32'(pass1), 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
